// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - cache/RAM handshake bundle for memory_arbiter
//
// Purpose: groups the icache, dcache and RAM signals of the arbiter.
// Modports:
//   slave  - the arbiter: takes cache requests and RAM status/data,
//            drives cache waits/loads and RAM enables/address/data/err.
//   master - the environment (caches + RAM model) on the other side.
// Signals:
//   iREN/iaddr, dREN/dWEN/daddr/dstore   cache requests
//   iwait/iload, dwait/dload             cache responses
//   ramREN/ramWEN/ramaddr/ramstore       RAM command
//   ramload/ramstate                     RAM response (00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR)
//   err                                  sticky error flag
interface memory_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        iwait;
   logic        dwait;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-requester (icache/dcache) single-RAM arbiter
//
// Purpose: serves one cache request at a time against a single RAM port.
// Ties are broken against the side granted last. A serve state completes on
// RAM ACCESS (real data), ERROR or timeout (BADWORD + sticky err), or is
// abandoned silently when the requester withdraws.
// Ports:
//   CLK   - system clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - memory_arbiter_if.slave (cache requests/responses, RAM port, err)
// Parameters:
//   TIMEOUT - max serve cycles without ACCESS before giving up
//   BADWORD - load value returned on error/timeout
module memory_arbiter #(
   parameter int          TIMEOUT = 255,
   parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
   input logic              CLK,
   input logic              nRST,
   memory_arbiter_if.slave  bus
);
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] RS_ACCESS = 2'b10;
   localparam logic [1:0] RS_ERROR  = 2'b11;

   typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

   state_t        state;
   logic          last_grant;   // 0 = icache, 1 = dcache
   logic [CW-1:0] cnt;
   logic          err_q;

   logic ireq, dreq, serve_req, done_ok, done_bad;

   assign ireq      = bus.iREN;
   assign dreq      = bus.dREN | bus.dWEN;
   assign serve_req = (state == ISERV) ? ireq : (state == DSERV) ? dreq : 1'b0;
   // ACCESS takes priority over a coincident timeout: the data is genuine.
   assign done_ok   = serve_req && (bus.ramstate == RS_ACCESS);
   assign done_bad  = serve_req && !done_ok &&
                      ((bus.ramstate == RS_ERROR) || (cnt == CW'(TIMEOUT)));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (ireq && dreq)
                  state <= last_grant ? ISERV : DSERV;
               else if (dreq)
                  state <= DSERV;
               else if (ireq)
                  state <= ISERV;
            end
            ISERV, DSERV: begin
               if (!serve_req) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (done_ok || done_bad) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  last_grant <= (state == DSERV);
                  if (done_bad)
                     err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are combinational from state and inputs so a completion is seen
   // in the same cycle the RAM reports ACCESS/ERROR. Reset forces IDLE, which
   // makes every output take its reset value immediately.
   always_comb begin
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.iload    = '0;
      bus.dload    = '0;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.err      = err_q;
      if (serve_req) begin
         if (state == ISERV) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
            if (done_ok || done_bad) begin
               bus.iwait = 1'b0;
               bus.iload = done_ok ? bus.ramload : BADWORD;
            end
         end else begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = !bus.dWEN;
            if (done_ok || done_bad) begin
               bus.dwait = 1'b0;
               if (done_bad)
                  bus.dload = BADWORD;
               else if (!bus.dWEN)
                  bus.dload = bus.ramload;
            end
         end
      end
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter
module tb_memory_arbiter;
   localparam int          TMO = 4;
   localparam logic [31:0] BAD = 32'hBAD1BAD1;

   typedef struct packed {
      logic        iwait;
      logic        dwait;
      logic [31:0] iload;
      logic [31:0] dload;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic        err;
   } obs_t;

   logic clk;
   logic nrst;
   memory_arbiter_if bus();

   memory_arbiter #(.TIMEOUT(TMO), .BADWORD(BAD)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   obs_t sb[$];

   // Reference model: who is being served (0 none, 1 icache, 2 dcache),
   // how many serve cycles have passed without completion, which side won
   // last, and whether an error has been seen.
   int m_serv;
   int m_elapsed;
   bit m_last_d;
   bit m_err;

   localparam obs_t RESET_OBS = '{iwait: 1'b1, dwait: 1'b1, iload: '0, dload: '0,
                                  ren: 1'b0, wen: 1'b0, addr: '0, store: '0, err: 1'b0};

   function automatic obs_t sample();
      obs_t o;
      o.iwait = bus.iwait;  o.dwait = bus.dwait;
      o.iload = bus.iload;  o.dload = bus.dload;
      o.ren   = bus.ramREN; o.wen   = bus.ramWEN;
      o.addr  = bus.ramaddr; o.store = bus.ramstore;
      o.err   = bus.err;
      return o;
   endfunction

   task automatic model_reset();
      m_serv = 0; m_elapsed = 0; m_last_d = 1'b1; m_err = 1'b0;
   endtask

   // Drive one cycle of inputs, queue what the design must show this cycle,
   // advance the model past the next rising edge.
   task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] ds,
                        input logic [1:0] rs, input logic [31:0] rl);
      obs_t e;
      bit   wants;
      bit   finish;
      bit   good;
      bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
      bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = rl;
      e = RESET_OBS;
      e.err = m_err;
      if (m_serv == 0) begin
         if (ir && (dr || dw)) m_serv = m_last_d ? 1 : 2;
         else if (dr || dw)    m_serv = 2;
         else if (ir)          m_serv = 1;
         m_elapsed = 0;
      end else begin
         wants = (m_serv == 1) ? ir : (dr || dw);
         if (!wants) begin
            m_serv = 0; m_elapsed = 0;
         end else begin
            good   = (rs == 2'b10);
            finish = good || (rs == 2'b11) || (m_elapsed == TMO);
            if (m_serv == 1) begin
               e.ren = 1'b1; e.addr = ia;
               if (finish) begin e.iwait = 1'b0; e.iload = good ? rl : BAD; end
            end else begin
               e.addr = da; e.store = ds; e.wen = dw; e.ren = !dw;
               if (finish) begin
                  e.dwait = 1'b0;
                  e.dload = !good ? BAD : (dw ? 32'h0 : rl);
               end
            end
            if (finish) begin
               if (!good) m_err = 1'b1;
               m_last_d = (m_serv == 2);
               m_serv = 0; m_elapsed = 0;
            end else begin
               m_elapsed++;
            end
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_now(input string name);
      obs_t g;
      g = sample();
      checks++;
      if (g !== RESET_OBS) begin
         errors++;
         $display("FAIL %s got %h required %h", name, g, RESET_OBS);
      end
   endtask

   // Asynchronous reset in the second half of a cycle, after the monitor
   // has consumed that cycle's entry.
   task automatic pulse_reset(input string name);
      @(negedge clk);
      #2;
      nrst = 1'b0;
      #1;
      check_reset_now(name);
      model_reset();
      @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   // Monitor: compares each sampled cycle against the scoreboard head.
   initial begin
      obs_t exp_o;
      obs_t got_o;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_o = sb.pop_front();
            got_o = sample();
            checks++;
            if (got_o !== exp_o) begin
               errors++;
               $display("FAIL cycle_check t=%0t got %h required %h", $time, got_o, exp_o);
            end
         end
      end
   end

   initial begin
      nrst = 1'b0;
      bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = 0; bus.dstore = 0; bus.ramstate = 2'b00; bus.ramload = 0;
      model_reset();
      #3;
      check_reset_now("reset_state");
      @(posedge clk); @(posedge clk);
      #1;
      nrst = 1'b1;

      // icache read with two BUSY cycles then ACCESS
      drive(1, 32'h40, 0, 0, 0, 0, 2'b01, 0);
      drive(1, 32'h40, 0, 0, 0, 0, 2'b01, 0);
      drive(1, 32'h40, 0, 0, 0, 0, 2'b01, 0);
      drive(1, 32'h40, 0, 0, 0, 0, 2'b10, 32'h8C010004);
      drive(0, 32'h40, 0, 0, 0, 0, 2'b00, 0);

      // both pending from reset: I first, then alternate
      pulse_reset("reset_before_tie");
      for (int i = 0; i < 9; i++)
         drive(1, 32'h200 + i, 1, 0, 32'h300 + i, 0, 2'b10, 32'h1000 + i);
      drive(0, 0, 0, 0, 0, 0, 2'b00, 0);

      // write with dREN also high: write wins, dload stays 0
      drive(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 2'b01, 32'h5555);
      drive(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 2'b10, 32'h5555);
      drive(0, 0, 0, 0, 0, 0, 2'b00, 0);

      // timeout with BUSY held, err sticky afterwards
      for (int i = 0; i < 6; i++)
         drive(0, 0, 1, 0, 32'h80, 0, 2'b01, 32'h77);
      for (int i = 0; i < 3; i++)
         drive(0, 0, 0, 0, 0, 0, 2'b00, 0);

      // ERROR on the first serve cycle
      pulse_reset("reset_before_error");
      drive(0, 0, 1, 0, 32'h84, 0, 2'b11, 32'h99);
      drive(0, 0, 1, 0, 32'h84, 0, 2'b11, 32'h99);
      drive(0, 0, 0, 0, 0, 0, 2'b00, 0);

      // withdraw during ISERV, then reset mid-DSERV
      pulse_reset("reset_before_abort");
      drive(1, 32'h44, 0, 0, 0, 0, 2'b01, 0);
      drive(1, 32'h44, 0, 0, 0, 0, 2'b01, 0);
      drive(0, 32'h44, 1, 0, 32'h88, 0, 2'b01, 0);
      drive(0, 0, 1, 0, 32'h88, 0, 2'b01, 0);
      drive(0, 0, 1, 0, 32'h88, 0, 2'b01, 0);
      pulse_reset("reset_mid_dserv");

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         logic [1:0] rs;
         int         r;
         r = $urandom_range(0, 99);
         rs = (r < 40) ? 2'b10 : (r < 75) ? 2'b01 : (r < 93) ? 2'b00 : 2'b11;
         drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
               $urandom_range(0, 3) == 0, $urandom, $urandom, rs, $urandom);
         if ((n % 400) == 399)
            pulse_reset("reset_random");
      end

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in a serve state without ramstate==ACCESS.
REQ-002 Parameter BADWORD, default 32'hBAD1BAD1: load value returned on error or timeout.
REQ-003 CLK  in  1  system clock; all state updates on rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 iREN  in  1  icache read request.
REQ-006 iaddr  in  32  icache word address.
REQ-007 dREN  in  1  dcache read request.
REQ-008 dWEN  in  1  dcache write request.
REQ-009 daddr  in  32  dcache word address.
REQ-010 dstore  in  32  dcache write data.
REQ-011 iwait  out  1  high = icache request not complete this cycle.
REQ-012 dwait  out  1  high = dcache request not complete this cycle.
REQ-013 iload  out  32  icache read data, valid when iwait low.
REQ-014 dload  out  32  dcache read data, valid when dwait low after a read.
REQ-015 ramREN  out  1  RAM read enable.
REQ-016 ramWEN  out  1  RAM write enable.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
REQ-021 err  out  1  sticky error flag: ERROR seen or timeout occurred.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, ISERV, DSERV, plus a 1-bit last_grant register (0=I, 1=D) and a timeout counter of width clog2(TIMEOUT+1).
REQ-023 IDLE, d request only (dREN|dWEN) -> DSERV; i request only -> ISERV; both pending -> grant the side opposite last_grant; no request -> stay IDLE.
REQ-024 In IDLE all RAM enables SHALL be 0 and iwait=dwait=1.
REQ-025 ISERV: ramREN=1, ramWEN=0, ramaddr=iaddr, combinationally.
REQ-026 DSERV: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins over simultaneous dREN); otherwise ramREN=1.
REQ-027 Serve state with ramstate==ACCESS: same cycle the served wait goes low and load=ramload (dload updated only for a read); next state IDLE; last_grant set to served side; counter cleared.
REQ-028 Serve state with ramstate FREE or BUSY: served wait stays high; counter increments each cycle.
REQ-029 Serve state with ramstate==ERROR, or counter==TIMEOUT: served wait goes low, load=BADWORD, err set, next state IDLE, last_grant updated, counter cleared.
REQ-030 Requester deasserts its request while being served: no wait deassertion, RAM enables drop that cycle, next state IDLE, last_grant unchanged, counter cleared.
REQ-031 The unserved side's wait SHALL remain 1 at all times.
REQ-032 Minimum latency SHALL be 2 cycles from request assertion in IDLE to wait low (1 cycle to enter serve state, ACCESS on the first serve cycle); there is no back-to-back completion without an IDLE cycle.
REQ-033 iload/dload SHALL be 0 whenever the corresponding wait is high.
REQ-034 err SHALL clear only on reset.

Reset
REQ-035 nRST low SHALL immediately force state=IDLE, last_grant=1 (icache wins the first tie), counter=0, err=0, iwait=dwait=1, loads=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-036 Reset asserted mid-service SHALL abandon the transfer with no wait deassertion; after release the FSM starts in IDLE.

Verification
REQ-037 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 in ISERV; iwait low on ACCESS cycle with iload=0x8C010004; IDLE next.
REQ-038 iREN and dREN both asserted after reset, immediate ACCESS -> icache served first, then dcache; iREN held continuously -> grants alternate I,D,I,D.
REQ-039 dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low on ACCESS; dload=0.
REQ-040 dREN=1, ramstate held BUSY, TIMEOUT=4 -> dwait low exactly 4 serve cycles after entry, dload=0xBAD1BAD1, err=1 and stays 1.
REQ-041 dREN=1, ramstate=ERROR on the first DSERV cycle -> dwait low that cycle, dload=BADWORD, err=1.
REQ-042 iREN dropped after 1 BUSY cycle in ISERV, then nRST pulsed mid-DSERV -> abort to IDLE with iwait never low; all outputs at reset values asynchronously.
